// File: rtl/sample_rom_pkg.sv
// Shared defaults and types for the sample-ROM arbiter slice.
// Optional feature macro used by the slice: SAMPLE_ROM_PREFETCH_EN.
package sample_rom_pkg;

    localparam int unsigned NUM_CH_DEF = 2;
    localparam int unsigned CH_AW_DEF  = 24;
    localparam int unsigned SDR_AW_DEF = 27;

    typedef enum logic {
        StIdle,
        StBusy
    } arb_state_e;

    // Width of a channel index; at least one bit so single-channel builds stay legal.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sample_rom_channel.sv
// One sample-ROM read channel: strobe edge detect, address capture, held word,
// ready flag and (with SAMPLE_ROM_PREFETCH_EN defined) a single prefetch word.
module sample_rom_channel
    import sample_rom_pkg::*;
#(
    parameter int unsigned CH_AW = CH_AW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             oe_n_i,
    input  logic [CH_AW-1:0] addr_i,
    input  logic             grant_i,
    input  logic             busy_i,      // demand fetch for this channel in flight
    input  logic             done_i,
    input  logic [CH_AW-2:0] done_word_i,
    input  logic [15:0]      done_data_i,
`ifdef SAMPLE_ROM_PREFETCH_EN
    input  logic             pf_grant_i,
    input  logic             pf_done_i,
    output logic             pf_want_o,
    output logic [CH_AW-2:0] pf_word_o,
`endif
    output logic             pending_o,
    output logic [CH_AW-2:0] word_o,
    output logic [7:0]       data_o,
    output logic             ready_o
);

    localparam int unsigned WW = CH_AW - 1;

    logic             oe_q;
    logic [CH_AW-1:0] addr_q, addr_d;
    logic [WW-1:0]    hword_q, hword_d;
    logic [15:0]      hdata_q, hdata_d;
    logic             valid_q, valid_d;
    logic             pend_q, pend_d;
    logic             rdy_q, rdy_d;
    logic             fall;
    logic             held_hit;
    logic [WW-1:0]    new_word, cur_word;

`ifdef SAMPLE_ROM_PREFETCH_EN
    logic [WW-1:0]    pf_word_q, pf_word_d;
    logic [15:0]      pf_data_q, pf_data_d;
    logic             pf_valid_q, pf_valid_d;
    logic             pf_want_q, pf_want_d;
`endif

    assign fall     = oe_q & ~oe_n_i;
    assign new_word = addr_i[CH_AW-1:1];
    assign cur_word = addr_q[CH_AW-1:1];

    // Next-state for capture, held word, pending and ready.
    always_comb begin
        addr_d   = addr_q;
        hword_d  = hword_q;
        hdata_d  = hdata_q;
        valid_d  = valid_q;
        pend_d   = pend_q;
        rdy_d    = rdy_q;
        held_hit = 1'b0;
`ifdef SAMPLE_ROM_PREFETCH_EN
        pf_word_d  = pf_word_q;
        pf_data_d  = pf_data_q;
        pf_valid_d = pf_valid_q;
        pf_want_d  = pf_want_q;
        if (pf_grant_i) begin
            pf_want_d = 1'b0;
        end
`endif
        if (grant_i) begin
            pend_d = 1'b0;
        end
        if (done_i) begin
            hword_d = done_word_i;
            hdata_d = done_data_i;
            valid_d = 1'b1;
            if (cur_word == done_word_i) begin
                rdy_d = 1'b1;
`ifdef SAMPLE_ROM_PREFETCH_EN
                pf_want_d  = 1'b1;
                pf_word_d  = done_word_i + WW'(1);
                pf_valid_d = 1'b0;
`endif
            end else begin
                // Address moved on while the fetch was out: fetch again.
                rdy_d  = 1'b0;
                pend_d = 1'b1;
            end
        end
`ifdef SAMPLE_ROM_PREFETCH_EN
        if (pf_done_i) begin
            pf_data_d  = done_data_i;
            pf_valid_d = (done_word_i == pf_word_q);
        end
`endif
        // A new strobe is judged against the held word as it stands after this cycle.
        if (fall) begin
            addr_d   = addr_i;
            held_hit = valid_d && (new_word == hword_d);
            if (held_hit) begin
                pend_d = 1'b0;
                if (done_i || !busy_i) begin
                    rdy_d = 1'b1;
                end
            end
`ifdef SAMPLE_ROM_PREFETCH_EN
            else if (pf_valid_q && (new_word == pf_word_q)) begin
                hword_d    = pf_word_q;
                hdata_d    = pf_data_q;
                valid_d    = 1'b1;
                pend_d     = 1'b0;
                rdy_d      = 1'b1;
                pf_valid_d = 1'b0;
            end
`endif
            else begin
                pend_d = 1'b1;
                rdy_d  = 1'b0;
            end
        end
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            oe_q    <= 1'b1;
            addr_q  <= '0;
            hword_q <= '0;
            hdata_q <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef SAMPLE_ROM_PREFETCH_EN
            pf_word_q  <= '0;
            pf_data_q  <= '0;
            pf_valid_q <= 1'b0;
            pf_want_q  <= 1'b0;
`endif
        end else begin
            oe_q    <= oe_n_i;
            addr_q  <= addr_d;
            hword_q <= hword_d;
            hdata_q <= hdata_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            rdy_q   <= rdy_d;
`ifdef SAMPLE_ROM_PREFETCH_EN
            pf_word_q  <= pf_word_d;
            pf_data_q  <= pf_data_d;
            pf_valid_q <= pf_valid_d;
            pf_want_q  <= pf_want_d;
`endif
        end
    end

`ifdef SAMPLE_ROM_PREFETCH_EN
    assign pf_want_o = pf_want_q;
    assign pf_word_o = pf_word_q;
`endif
    assign pending_o = pend_q;
    assign word_o    = cur_word;
    assign data_o    = addr_q[0] ? hdata_q[15:8] : hdata_q[7:0];
    assign ready_o   = rdy_q;

endmodule

// File: rtl/sample_rom_arbiter.sv
// Round-robin arbiter sharing one toggle-handshake SDRAM port between the
// sample-ROM read channels. Optional prefetch: SAMPLE_ROM_PREFETCH_EN.
module sample_rom_arbiter
    import sample_rom_pkg::*;
#(
    parameter int unsigned              NUM_CH  = NUM_CH_DEF,
    parameter int unsigned              CH_AW   = CH_AW_DEF,
    parameter int unsigned              SDR_AW  = SDR_AW_DEF,
    parameter logic [NUM_CH*SDR_AW-1:0] CH_BASE = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       ch_oe_n,
    input  logic [NUM_CH*CH_AW-1:0] ch_addr,
    output logic [NUM_CH*8-1:0]     ch_data,
    output logic [NUM_CH-1:0]       ch_ready,
    output logic [SDR_AW-1:0]       sdr_address,
    output logic                    sdr_req,
    input  logic [15:0]             sdr_data,
    input  logic                    sdr_ack
);

    localparam int unsigned IW = idx_width(NUM_CH);
    localparam int unsigned WW = CH_AW - 1;

    arb_state_e        state_q, state_d;
    logic              req_q, req_d;
    logic [SDR_AW-1:0] addr_q, addr_d;
    logic [IW-1:0]     last_q, last_d;
    logic [IW-1:0]     cur_q, cur_d;
    logic [WW-1:0]     curw_q, curw_d;

    logic [NUM_CH-1:0] pending, grant, done, busy_ch;
    logic [WW-1:0]     words [NUM_CH];
    logic              hs_idle, done_any, gnt_any, cur_is_pf;
    logic [IW-1:0]     gnt_idx, cand;

`ifdef SAMPLE_ROM_PREFETCH_EN
    logic [NUM_CH-1:0] pf_want, pf_grant, pf_done;
    logic [WW-1:0]     pf_words [NUM_CH];
    logic              curpf_q, curpf_d;
    logic              pf_any;
    logic [IW-1:0]     pf_idx;

    assign cur_is_pf = curpf_q;
`else
    assign cur_is_pf = 1'b0;
`endif

    // The port is free to act only when no handshake is outstanding.
    assign hs_idle = (req_q == sdr_ack);

    // Round-robin pick: first pending channel strictly after the last grant.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        for (int k = 1; k <= int'(NUM_CH); k++) begin
            cand = IW'((int'(last_q) + k) % int'(NUM_CH));
            if (!gnt_any && pending[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
    end

`ifdef SAMPLE_ROM_PREFETCH_EN
    // Prefetch pick: lowest-index channel wanting a prefetch.
    always_comb begin
        pf_any = 1'b0;
        pf_idx = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (pf_want[i]) begin
                pf_any = 1'b1;
                pf_idx = IW'(i);
            end
        end
    end
`endif

    // Arbiter next-state, grant and completion decode.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        addr_d   = addr_q;
        last_d   = last_q;
        cur_d    = cur_q;
        curw_d   = curw_q;
        grant    = '0;
        done_any = 1'b0;
`ifdef SAMPLE_ROM_PREFETCH_EN
        curpf_d  = curpf_q;
        pf_grant = '0;
`endif
        unique case (state_q)
            StIdle: begin
                if (hs_idle) begin
                    if (gnt_any) begin
                        grant[gnt_idx] = 1'b1;
                        addr_d  = CH_BASE[int'(gnt_idx)*SDR_AW +: SDR_AW]
                                + SDR_AW'({words[gnt_idx], 1'b0});
                        req_d   = ~req_q;
                        last_d  = gnt_idx;
                        cur_d   = gnt_idx;
                        curw_d  = words[gnt_idx];
                        state_d = StBusy;
`ifdef SAMPLE_ROM_PREFETCH_EN
                        curpf_d = 1'b0;
`endif
                    end
`ifdef SAMPLE_ROM_PREFETCH_EN
                    else if (pf_any) begin
                        pf_grant[pf_idx] = 1'b1;
                        addr_d  = CH_BASE[int'(pf_idx)*SDR_AW +: SDR_AW]
                                + SDR_AW'({pf_words[pf_idx], 1'b0});
                        req_d   = ~req_q;
                        cur_d   = pf_idx;
                        curw_d  = pf_words[pf_idx];
                        curpf_d = 1'b1;
                        state_d = StBusy;
                    end
`endif
                end
            end
            StBusy: begin
                if (hs_idle) begin
                    done_any = 1'b1;
                    state_d  = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Arbiter state registers; reset abandons any request in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            addr_q  <= '0;
            last_q  <= IW'(NUM_CH - 1);
            cur_q   <= '0;
            curw_q  <= '0;
`ifdef SAMPLE_ROM_PREFETCH_EN
            curpf_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
            cur_q   <= cur_d;
            curw_q  <= curw_d;
`ifdef SAMPLE_ROM_PREFETCH_EN
            curpf_q <= curpf_d;
`endif
        end
    end

    assign sdr_req     = req_q;
    assign sdr_address = addr_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign done[i]    = done_any && (cur_q == IW'(i)) && !cur_is_pf;
        assign busy_ch[i] = (state_q == StBusy) && (cur_q == IW'(i)) && !cur_is_pf;
`ifdef SAMPLE_ROM_PREFETCH_EN
        assign pf_done[i] = done_any && (cur_q == IW'(i)) && cur_is_pf;
`endif

        sample_rom_channel #(
            .CH_AW (CH_AW)
        ) u_channel (
            .clk         (clk),
            .reset       (reset),
            .oe_n_i      (ch_oe_n[i]),
            .addr_i      (ch_addr[i*CH_AW +: CH_AW]),
            .grant_i     (grant[i]),
            .busy_i      (busy_ch[i]),
            .done_i      (done[i]),
            .done_word_i (curw_q),
            .done_data_i (sdr_data),
`ifdef SAMPLE_ROM_PREFETCH_EN
            .pf_grant_i  (pf_grant[i]),
            .pf_done_i   (pf_done[i]),
            .pf_want_o   (pf_want[i]),
            .pf_word_o   (pf_words[i]),
`endif
            .pending_o   (pending[i]),
            .word_o      (words[i]),
            .data_o      (ch_data[i*8 +: 8]),
            .ready_o     (ch_ready[i])
        );
    end

endmodule

// File: doc/sample_rom_arbiter.md
SAMPLE_ROM_ARBITER -- requirements
Module: sample_rom_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, number of sample-ROM read channels (1..8).
REQ-002 SHALL have parameter CH_AW, default 24, channel byte-address width.
REQ-003 SHALL have parameter SDR_AW, default 27, SDRAM byte-address width.
REQ-004 SHALL have parameter CH_BASE, default all-zero, NUM_CH*SDR_AW-bit packed per-channel SDRAM base; channel i occupies slice i.
REQ-005 SHALL have ports clk (in, 1, sole clock) and reset (in, 1, synchronous active-high reset); one clock, synchronous active-high reset.
REQ-006 SHALL have port ch_oe_n (in, NUM_CH): per-channel read strobe, active low.
REQ-007 SHALL have port ch_addr (in, NUM_CH*CH_AW): per-channel byte address.
REQ-008 SHALL have port ch_data (out, NUM_CH*8): per-channel selected byte.
REQ-009 SHALL have port ch_ready (out, NUM_CH): held byte is valid for the last captured address.
REQ-010 SHALL have ports sdr_address (out, SDR_AW), sdr_req (out, 1), sdr_data (in, 16) and sdr_ack (in, 1) forming the toggle handshake.

Function
REQ-011 SHALL register ch_oe_n each cycle; falling edge = registered high and current low.
REQ-012 SHALL capture ch_addr on a channel's falling edge and set pending if the word address (addr[CH_AW-1:1]) differs from the held word or the held word is invalid; it SHALL clear ch_ready the same cycle.
REQ-013 SHALL leave pending clear and ch_ready unchanged when the captured word equals the valid held word (byte-only change).
REQ-014 SHALL drive ch_data as held word [15:8] when captured addr[0]=1, else [7:0].
REQ-015 SHALL run an arbiter with states IDLE and BUSY, acting only when sdr_req==sdr_ack.
REQ-016 SHALL, in IDLE with any pending, grant round-robin: lowest-index pending channel strictly after the last granted channel, wrapping.
REQ-017 SHALL, on grant: sdr_address = CH_BASE[i] + zero-extended {word, 1'b0} modulo 2^SDR_AW; toggle sdr_req; clear pending[i]; record channel and word; enter BUSY.
REQ-018 SHALL, in BUSY with sdr_req==sdr_ack, write sdr_data into channel's held word, mark it valid, and return to IDLE; a grant SHALL NOT occur in the same cycle.
REQ-019 SHALL, at completion, set ch_ready only if the channel's captured word equals the recorded word; otherwise it SHALL leave ch_ready low with pending set (re-fetch).
REQ-020 SHALL, on an edge coinciding with completion for the same channel, evaluate the new address against the completed word.
REQ-021 SHALL keep sdr_address stable while BUSY.
REQ-022 SHALL have one-request latency: grant-to-ready = SDRAM ack delay + 1 cycle.

Reset
REQ-023 SHALL on reset clear pending, valid and ch_ready, set sdr_req=0, sdr_address=0, held words=0, last-granted=NUM_CH-1, and state IDLE.
REQ-024 SHALL abandon any in-flight request on reset; sdr_ack's source SHALL be reset concurrently.

Configuration
REQ-025 SHALL, with SAMPLE_ROM_PREFETCH_EN defined, keep a per-channel prefetch word; after a demand completion with no pending, it SHALL issue a fetch of word+1 for that channel (lowest priority).
REQ-026 SHALL, with SAMPLE_ROM_PREFETCH_EN, treat an edge whose word equals a valid prefetch word as a hit: promote it to held word and set ch_ready the next cycle without an SDRAM request.
REQ-027 SHALL, without SAMPLE_ROM_PREFETCH_EN, have no prefetch storage; every word change fetches.

Structure
REQ-028 SHALL place the arbiter-state typedef and NUM_CH/CH_AW/SDR_AW defaults in package sample_rom_pkg.
REQ-029 SHALL instantiate sub-module sample_rom_channel per channel (edge detect, capture, held/prefetch word, ready).

Verification
REQ-030 SHALL verify: ch0 edge, addr 0x000010, CH_BASE0=0x100000, ack after 5 cycles, data 0xBEEF -> sdr_address 0x100010; ch_ready0 rises; ch_data0=0xEF.
REQ-031 SHALL verify: follow-up edge at 0x000011 -> no sdr_req toggle; ch_data0=0xBE within 1 cycle.
REQ-032 SHALL verify: ch0 and ch1 pending together, last-granted=0 -> ch1 granted first, then ch0.
REQ-033 SHALL verify: ch0 edge to 0x20 while its 0x10 fetch is BUSY -> ready stays low; second request 0x20 issued.
REQ-034 SHALL verify: reset asserted mid-BUSY -> sdr_req=0, all ch_ready=0, next edge fetches normally.
REQ-035 SHALL verify, with SAMPLE_ROM_PREFETCH_EN: fetch 0x10 then idle -> prefetch of 0x12 issued; edge 0x12 -> ready next cycle, no request.
